// File: rtl/clock_ctrl_pkg.sv
// Shared types for the fabric clock switch sequencer.
// Select encoding and controller state definitions.
package clock_ctrl_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    CLK_OFF     = 2'd0,
    CLK_REST    = 2'd1,
    CLK_NOMINAL = 2'd2,
    CLK_SPRINT  = 2'd3
  } clk_sel_t;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_ALIGN,
    ST_READY,
    ST_GATE,
    ST_SWITCH,
    ST_UNGATE
  } ctrl_state_t;

endpackage

// File: rtl/clk_phase_counter.sv
// Hyperperiod position tracker for the divider bank.
// Held at zero while the dividers are in reset.
module clk_phase_counter #(
  parameter int p_slow_div = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  output logic [$clog2(p_slow_div)-1:0] phase,
  output logic                          boundary
);

  localparam int PW = $clog2(p_slow_div);
  localparam logic [PW-1:0] LAST = PW'(p_slow_div - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (hold) begin
      phase <= '0;
    end else if (phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign boundary = (phase == LAST);

endmodule

// File: rtl/clock_switch_sequencer.sv
// Divider reset owner and glitch-free per-tile clock select sequencer.
// Gate, switch and ungate steps each land on a hyperperiod boundary.
module clock_switch_sequencer
  import clock_ctrl_pkg::*;
#(
  parameter int p_num_tiles   = 16,
  parameter int p_slow_div    = 9,
  parameter int p_hold_cycles = 4
) (
  input  logic                          clk,
  input  logic                          clk_reset_n,
  output logic                          div_clk_reset,
  input  logic                          cfg_val,
  output logic                          cfg_rdy,
  input  logic [2*p_num_tiles-1:0]      cfg_msg,
  output logic [2*p_num_tiles-1:0]      tile_clk_sel,
  output logic [p_num_tiles-1:0]        tile_clk_en,
  output logic                          clocks_ready,
  output logic [$clog2(p_slow_div)-1:0] phase
);

  localparam int N  = p_num_tiles;
  localparam int SW = SEL_W * N;
  localparam int HW = $clog2(p_hold_cycles + 1);
  localparam logic [SEL_W-1:0] NOM = CLK_NOMINAL;
  localparam logic [SEL_W-1:0] OFF = CLK_OFF;
  localparam logic [SW-1:0] SEL_RST = {N{NOM}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(p_hold_cycles - 1);

  ctrl_state_t   state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] pending;
  logic [N-1:0]  changed;
  logic [N-1:0]  diff;
  logic [N-1:0]  cur_on;
  logic [N-1:0]  pend_on;
  logic          boundary;

  clk_phase_counter #(
    .p_slow_div (p_slow_div)
  ) u_phase (
    .clk      (clk),
    .rst_n    (clk_reset_n),
    .hold     (div_clk_reset),
    .phase    (phase),
    .boundary (boundary)
  );

  always_comb begin
    diff    = '0;
    cur_on  = '0;
    pend_on = '0;
    for (int i = 0; i < N; i++) begin
      diff[i]    = cfg_msg[SEL_W*i +: SEL_W] != tile_clk_sel[SEL_W*i +: SEL_W];
      cur_on[i]  = tile_clk_sel[SEL_W*i +: SEL_W] != OFF;
      pend_on[i] = pending[SEL_W*i +: SEL_W] != OFF;
    end
  end

  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state         <= ST_HOLD;
      hold_cnt      <= '0;
      div_clk_reset <= 1'b1;
      pending       <= '0;
      changed       <= '0;
      tile_clk_sel  <= SEL_RST;
      tile_clk_en   <= '0;
      cfg_rdy       <= 1'b0;
      clocks_ready  <= 1'b0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            div_clk_reset <= 1'b0;
            state         <= ST_ALIGN;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_ALIGN: begin
          if (boundary) begin
            tile_clk_en  <= cur_on;
            clocks_ready <= 1'b1;
            state        <= ST_READY;
          end
        end
        ST_READY: begin
          // cfg_rdy rises one cycle after entry, so each request sees a gap
          if (cfg_val && cfg_rdy) begin
            pending <= cfg_msg;
            changed <= diff;
            cfg_rdy <= 1'b0;
            if (|diff) state <= ST_GATE;
          end else begin
            cfg_rdy <= 1'b1;
          end
        end
        ST_GATE: begin
          if (boundary) begin
            tile_clk_en <= tile_clk_en & ~changed;
            state       <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (boundary) begin
            tile_clk_sel <= pending;
            state        <= ST_UNGATE;
          end
        end
        ST_UNGATE: begin
          if (boundary) begin
            tile_clk_en <= (tile_clk_en & ~changed) | (pend_on & changed);
            state       <= ST_READY;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule
